ram_gray_engine: RTL and testbench

Block-transfer engine on the single-port pixel RAM (64K × 24-bit, RGB packed R[23:16] G[15:8] B[7:0]). On a START pulse it reads LEN pixels from SRC, converts each to grey, and writes {Y,Y,Y} to DST. It sits directly upstream of the RAM as its only master: it drives A/WE/OE/D and consumes Q. It observes the RAM's timing, where the address is latched at the CK edge and Q is valid only while OE is high in the following cycle.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/rgb2gray.sv | 20 ++
 rtl/ram_gray_engine.sv | 109 ++++++++++
 tb/tb_ram_gray_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_pkg : shared types and constants for the RAM grey engine      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gray_pkg;

   localparam int AW_DEFAULT = 16;
   localparam int DW_DEFAULT = 24;

   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rgb2gray.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rgb2gray : combinational Y = (R + 2G + B) / 4, truncated           |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rgb2gray
   import gray_pkg::*;
(
   input  logic [23:0] pix,
   output logic [7:0]  y
);

   logic [9:0] w_sum;

   // Max 255 + 510 + 255 = 1020 fits in 10 bits.
   assign w_sum = 10'(pix[R_MSB:R_LSB]) + {1'b0, pix[G_MSB:G_LSB], 1'b0} + 10'(pix[B_MSB:B_LSB]);
   assign y     = 8'(w_sum >> 2);

endmodule
`default_nettype wire

// File: rtl/ram_gray_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_gray_engine : block read -> grey -> write on single-port RAM   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ram_gray_engine
   import gray_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic          CK,
   input  logic          RST,
   input  logic          START,
   input  logic [AW-1:0] SRC,
   input  logic [AW-1:0] DST,
   input  logic [AW:0]   LEN,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW-1:0] A,
   output logic          WE,
   output logic          OE,
   output logic [DW-1:0] D,
   input  logic [DW-1:0] Q
);

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [AW:0]   r_remain;
   logic [DW-1:0] r_pix;
   logic [7:0]    w_y;

   rgb2gray u_rgb2gray (
      .pix (r_pix),
      .y   (w_y)
   );

   always_ff @(posedge CK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_remain <= '0;
         r_pix    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (START && (LEN != '0)) begin
                  r_src    <= SRC;
                  r_dst    <= DST;
                  r_remain <= LEN;
               end
            end
            RDATA: r_pix <= Q;
            WRITE: begin
               // Pointers wrap naturally at 2^AW.
               r_src    <= r_src + 1'b1;
               r_dst    <= r_dst + 1'b1;
               r_remain <= r_remain - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // RAM controls depend only on state and registered data, never on START or Q.
   always_comb begin
      w_next = r_state;
      BUSY   = 1'b0;
      DONE   = 1'b0;
      A      = '0;
      WE     = 1'b0;
      OE     = 1'b0;
      D      = '0;
      case (r_state)
         IDLE: begin
            if (START) w_next = (LEN == '0) ? FIN : RADDR;
         end
         RADDR: begin
            BUSY   = 1'b1;
            A      = r_src;
            w_next = RDATA;
         end
         RDATA: begin
            BUSY   = 1'b1;
            A      = r_src;
            OE     = 1'b1;
            w_next = WRITE;
         end
         WRITE: begin
            BUSY   = 1'b1;
            A      = r_dst;
            WE     = 1'b1;
            D      = DW'({w_y, w_y, w_y});
            w_next = (r_remain == (AW+1)'(1)) ? FIN : RADDR;
         end
         FIN: begin
            DONE   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_gray_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram_gray_engine : scoreboard bench with behavioural pixel RAM   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ram_gray_engine;

   logic        CK    = 1'b0;
   logic        RST   = 1'b1;
   logic        START = 1'b0;
   logic [15:0] SRC   = '0;
   logic [15:0] DST   = '0;
   logic [16:0] LEN   = '0;
   logic        BUSY, DONE, WE, OE;
   logic [15:0] A;
   logic [23:0] D;
   logic [23:0] Q;

   ram_gray_engine #(.AW(16), .DW(24)) dut (
      .CK(CK), .RST(RST), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
      .BUSY(BUSY), .DONE(DONE), .A(A), .WE(WE), .OE(OE), .D(D), .Q(Q)
   );

   always #5 CK = ~CK;

   // Pixel RAM: address latched at the edge, Q valid while OE is high.
   logic [23:0] mem [0:65535];
   logic [15:0] lat_a;
   logic        ld_en   = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [23:0] ld_data = '0;

   always @(posedge CK) begin
      lat_a <= A;
      if (WE)    mem[A]       <= D;
      if (ld_en) mem[ld_addr] <= ld_data;
   end
   assign Q = OE ? mem[lat_a] : 24'h0;

   typedef struct {
      logic [15:0] addr;
      logic [23:0] data;
      int          cyc;
   } wr_t;

   wr_t sb[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   int  we_cnt = 0;
   int  done_cnt = 0;
   int  busy_cnt = 0;
   int  oe_cnt = 0;
   int  t0 = 0;

   always @(posedge CK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [23:0] grey3(input logic [23:0] p);
      logic [9:0] s;
      s = {2'b0, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b0, p[7:0]};
      return {s[9:2], s[9:2], s[9:2]};
   endfunction

   // Output monitor: every write must match the head of the scoreboard.
   always @(negedge CK) begin
      if (BUSY) busy_cnt++;
      if (OE)   oe_cnt++;
      if (DONE) done_cnt++;
      if (WE) begin
         wr_t e;
         we_cnt++;
         check("sb_nonempty", sb.size(), (sb.size() == 0) ? 1 : sb.size());
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_addr", {16'h0, A}, {16'h0, e.addr});
            check("wr_data", {8'h0, D},  {8'h0, e.data});
            check("wr_cyc",  cyc,        e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [23:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic clear_counts();
      we_cnt = 0; done_cnt = 0; busy_cnt = 0; oe_cnt = 0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, BUSY, 0);
      check({tag, "_done"}, DONE, 0);
      check({tag, "_a"},    A,    0);
      check({tag, "_we"},   WE,   0);
      check({tag, "_oe"},   OE,   0);
      check({tag, "_d"},    D,    0);
   endtask

   // Pulse START and queue the expected writes for this block.
   task automatic start_run(input logic [15:0] s, input logic [15:0] d, input int n);
      SRC = s; DST = d; LEN = 17'(n); START = 1'b1;
      tick();
      START = 1'b0;
      t0 = cyc;
      for (int k = 0; k < n; k++) begin
         wr_t e;
         e.addr = d + 16'(k);
         e.data = grey3(mem[s + 16'(k)]);
         e.cyc  = t0 + 3*k + 2;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int n, input bit pulse_in_fin);
      int w = 0;
      do begin
         @(negedge CK);
         w++;
      end while (!DONE && w < 3*n + 10);
      check("done_seen", DONE, 1);
      check("done_cyc",  cyc,  t0 + 3*n);
      check("fin_busy",  BUSY, 0);
      if (pulse_in_fin) begin
         SRC = 16'h7000; DST = 16'h7100; LEN = 17'd3; START = 1'b1;
      end
      tick();
      START = 1'b0;
   endtask

   logic [23:0] p0;

   initial begin
      // Reset, then a second 2-cycle reset while idle.
      repeat (3) tick();
      RST = 1'b0;
      tick();
      clear_counts();
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      check_idle("rst");
      check("rst_we_cnt", we_cnt, 0);

      // Single pixel.
      load(16'h0010, 24'hFF8000);
      clear_counts();
      start_run(16'h0010, 16'h0020, 1);
      wait_done(1, 1'b0);
      check("single_dst", mem[16'h0020], 24'h7F7F7F);
      check("single_src", mem[16'h0010], 24'hFF8000);
      check("single_we_cnt", we_cnt, 1);

      // In place with address wrap.
      load(16'hFFFE, 24'hFFFFFF);
      load(16'hFFFF, 24'h000000);
      load(16'h0000, 24'h010101);
      load(16'h0001, 24'h102030);
      clear_counts();
      start_run(16'hFFFE, 16'hFFFE, 4);
      wait_done(4, 1'b0);
      check("wrap_fffe", mem[16'hFFFE], 24'hFFFFFF);
      check("wrap_ffff", mem[16'hFFFF], 24'h000000);
      check("wrap_0000", mem[16'h0000], 24'h010101);
      check("wrap_0001", mem[16'h0001], 24'h202020);

      // LEN = 0.
      clear_counts();
      start_run(16'h0040, 16'h0050, 0);
      wait_done(0, 1'b0);
      check("len0_busy_cnt", busy_cnt, 0);
      check("len0_we_cnt",   we_cnt,   0);
      check("len0_oe_cnt",   oe_cnt,   0);

      // LEN = 8 with START pulsed mid-run and again in FIN.
      for (int k = 0; k < 8; k++) load(16'h1000 + 16'(k), 24'($urandom));
      clear_counts();
      start_run(16'h1000, 16'h2000, 8);
      repeat (4) tick();
      SRC = 16'h5000; DST = 16'h6000; LEN = 17'd2; START = 1'b1;
      tick();
      START = 1'b0;
      wait_done(8, 1'b1);
      repeat (4) tick();
      check("ign_we_cnt",   we_cnt,     8);
      check("ign_done_cnt", done_cnt,   1);
      check("ign_sb_empty", sb.size(),  0);
      check("ign_idle",     BUSY,       0);

      // Reset in cycle 5 of a LEN = 8 run.
      for (int k = 0; k < 8; k++) load(16'h0100 + 16'(k), 24'($urandom));
      load(16'h0201, 24'hABCDEF);
      p0 = mem[16'h0100];
      clear_counts();
      start_run(16'h0100, 16'h0200, 8);
      repeat (4) tick();
      RST = 1'b1;
      tick();
      check_idle("midrst");
      RST = 1'b0;
      sb.delete();
      repeat (2) tick();
      check("midrst_pix0",   mem[16'h0200], grey3(p0));
      check("midrst_pix1",   mem[16'h0201], 24'hABCDEF);
      check("midrst_we_cnt", we_cnt, 1);

      // Normal run after the reset.
      clear_counts();
      start_run(16'h0100, 16'h0300, 3);
      wait_done(3, 1'b0);
      check("post_we_cnt",   we_cnt,    3);
      check("post_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
